// File: rtl/sine_period_meter.sv
// Period meter for a signed 8-bit sample stream: detects rising zero
// crossings with hysteresis and reports the mean of 2^LOG2_NPER periods
// (in sample strobes), plus lock and loss-of-signal status.
module sine_period_meter #(
  parameter int unsigned HYST       = 8,
  parameter int unsigned LOG2_NPER  = 2,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MIN_PERIOD = 4,
  parameter int unsigned MAX_PERIOD = 4096
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             step_in,
  input  logic [7:0]       amp_in,
  output logic [CNT_W-1:0] period_out,
  output logic             valid_out,
  output logic             locked_out,
  output logic             lost_out
);

  localparam int unsigned NPER  = 1 << LOG2_NPER;
  localparam int unsigned K_W   = (LOG2_NPER > 0) ? LOG2_NPER : 1;
  localparam int unsigned ACC_W = CNT_W + LOG2_NPER;
  localparam int unsigned PW    = CNT_W + 1;

  localparam logic signed [7:0] HYST_P = 8'(HYST);
  localparam logic signed [7:0] HYST_N = -HYST_P;
  localparam logic [PW-1:0]     MIN_P  = PW'(MIN_PERIOD);
  localparam logic [PW-1:0]     MAX_P  = PW'(MAX_PERIOD);
  localparam logic [K_W-1:0]    K_LAST = K_W'(NPER - 1);

  typedef enum logic {SEARCH, MEASURE} state_e;

  state_e             state_q, state_d;
  logic               pol_q, pol_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic               valid_q, valid_d;
  logic               locked_q, locked_d;
  logic               lost_q, lost_d;

  logic signed [7:0]  amp_s;
  logic               raw_ev, accept, timeout, last_k;
  logic [PW-1:0]      p_cand;
  logic [ACC_W-1:0]   sum;

  // Event qualification: hysteresis arming, glitch rejection and timeout
  always_comb begin
    amp_s   = $signed(amp_in);
    raw_ev  = step_in & ~pol_q & (amp_s >= HYST_P);
    p_cand  = PW'(cnt_q) + PW'(1);
    accept  = raw_ev & ((state_q == SEARCH) | (p_cand >= MIN_P));
    timeout = step_in & ~accept & (state_q == MEASURE) & (p_cand == MAX_P);
    last_k  = (k_q == K_LAST);
    sum     = acc_q + ACC_W'(p_cand);
  end

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= SEARCH;
    else        state_q <= state_d;
  end

  // Next-state logic: first crossing starts a measurement, timeout aborts it
  always_comb begin
    state_d = state_q;
    if (accept && state_q == SEARCH) state_d = MEASURE;
    else if (timeout)                state_d = SEARCH;
  end

  // Datapath and output next values
  always_comb begin
    pol_d    = pol_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    k_d      = k_q;
    period_d = period_q;
    locked_d = locked_q;
    valid_d  = 1'b0;
    lost_d   = 1'b0;
    if (step_in) begin
      if (raw_ev)                         pol_d = 1'b1;
      else if (pol_q && amp_s <= HYST_N)  pol_d = 1'b0;

      if (accept || timeout)   cnt_d = '0;
      else if (cnt_q != '1)    cnt_d = cnt_q + CNT_W'(1);

      if (accept) begin
        if (state_q == SEARCH) begin
          acc_d = '0;
          k_d   = '0;
        end else if (last_k) begin
          period_d = CNT_W'(sum >> LOG2_NPER);
          valid_d  = 1'b1;
          locked_d = 1'b1;
          acc_d    = '0;
          k_d      = '0;
        end else begin
          acc_d = sum;
          k_d   = k_q + K_W'(1);
        end
      end else if (timeout) begin
        acc_d    = '0;
        k_d      = '0;
        locked_d = 1'b0;
        lost_d   = locked_q;
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pol_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      k_q      <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      pol_q    <= pol_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      k_q      <= k_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      lost_q   <= lost_d;
    end
  end

  assign period_out = period_q;
  assign valid_out  = valid_q;
  assign locked_out = locked_q;
  assign lost_out   = lost_q;

endmodule

// File: tb/tb_sine_period_meter.sv
// Bench for sine_period_meter: directed scenarios plus randomized square
// waves, checked every clock against a period-list reference model.
module tb_sine_period_meter;

  localparam int HYST  = 8;
  localparam int MIN_P = 4;
  localparam int MAX_P = 4096;
  localparam int NPER  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        step = 1'b0;
  logic [7:0]  amp = 8'd0;
  logic [15:0] period;
  logic        valid, locked, lost;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  bit     m_pol, m_meas, m_lock, e_valid, e_lost;
  int     m_period;
  longint idx, last_idx;
  int     per_q[$];
  int     n_valid, n_lost;

  always #5 clk = ~clk;

  sine_period_meter #(
    .HYST(8), .LOG2_NPER(2), .CNT_W(16), .MIN_PERIOD(4), .MAX_PERIOD(4096)
  ) dut (
    .clk_in(clk), .rst_in(rst), .step_in(step), .amp_in(amp),
    .period_out(period), .valid_out(valid), .locked_out(locked), .lost_out(lost)
  );

  function automatic void model_reset();
    m_pol = 0; m_meas = 0; m_lock = 0; e_valid = 0; e_lost = 0;
    m_period = 0; idx = 0; last_idx = 0;
    per_q.delete();
  endfunction

  // One sample strobe: period = distance in strobes between accepted crossings
  function automatic void model_step(int a);
    longint p;
    bit raw, acc;
    int s;
    idx++;
    p = idx - last_idx;
    raw = !m_pol && (a >= HYST);
    if (raw) m_pol = 1;
    else if (m_pol && a <= -HYST) m_pol = 0;
    acc = raw && (!m_meas || p >= MIN_P);
    if (acc) begin
      last_idx = idx;
      if (!m_meas) begin
        m_meas = 1;
        per_q.delete();
      end else begin
        per_q.push_back(int'(p));
        if (per_q.size() == NPER) begin
          s = 0;
          foreach (per_q[j]) s += per_q[j];
          m_period = s / NPER;
          e_valid = 1;
          m_lock = 1;
          per_q.delete();
        end
      end
    end else if (m_meas && p == MAX_P) begin
      m_meas = 0;
      last_idx = idx;
      per_q.delete();
      e_lost = m_lock;
      m_lock = 0;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one clock, advance the model, compare all outputs
  task automatic tick(input bit s, input int a, input string tag);
    step = s;
    amp = 8'(a);
    @(posedge clk);
    #1;
    e_valid = 0;
    e_lost = 0;
    if (s) model_step(a);
    if (valid === 1'b1) n_valid++;
    if (lost === 1'b1) n_lost++;
    vectors++;
    assert (period === 16'(m_period) && valid === e_valid &&
            locked === m_lock && lost === e_lost) else begin
      miscompares++;
      $error("FAIL %s: observed period=%0d valid=%b locked=%b lost=%b expected period=%0d valid=%b locked=%b lost=%b",
             tag, period, valid, locked, lost, m_period, e_valid, m_lock, e_lost);
    end
  endtask

  // Reset asserted between clock edges; outputs must clear without a clock
  task automatic apply_reset(input string tag);
    step = 0;
    #2 rst = 1'b1;
    #1;
    check({tag, "_period"}, 32'(period), 32'd0);
    check({tag, "_valid"},  32'(valid),  32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_lost"},   32'(lost),   32'd0);
    model_reset();
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic sine(input int n, input int periods, input int gap, input string tag);
    for (int i = 0; i < n * periods; i++) begin
      tick(1'b1, $rtoi(127.0 * $sin(2.0 * 3.14159265358979 * real'(i) / real'(n))), tag);
      for (int g = 1; g < gap; g++) tick(1'b0, int'($urandom_range(0, 255)) - 128, tag);
    end
  endtask

  task automatic sq(input int p, input int hi, input int lo, input int gap, input string tag);
    for (int i = 0; i < p; i++) begin
      tick(1'b1, (i < p / 2) ? hi : lo, tag);
      for (int g = 1; g < gap; g++) tick(1'b0, int'($urandom_range(0, 255)) - 128, tag);
    end
  endtask

  initial begin
    model_reset();
    apply_reset("por");

    // 64-step sine, strobe every clock
    n_valid = 0;
    sine(64, 10, 1, "sine64");
    check("sine64_period", 32'(period), 32'd64);
    check("sine64_locked", 32'(locked), 32'd1);
    check("sine64_nvalid", 32'(n_valid), 32'd2);

    // reset in the middle of a measurement, then relock
    sine(64, 2, 1, "sine64_pre");
    apply_reset("midrst");
    n_valid = 0;
    sine(64, 5, 1, "sine64_post");
    check("post_nvalid", 32'(n_valid), 32'd1);
    check("post_period", 32'(period), 32'd64);

    // 32-step sine, strobe every third clock
    apply_reset("rst_s32");
    sine(32, 10, 3, "sine32");
    check("sine32_period", 32'(period), 32'd32);

    // square wave averaging and truncation
    apply_reset("rst_sq");
    sq(60, 100, -100, 1, "sq_a"); sq(62, 100, -100, 1, "sq_a");
    sq(66, 100, -100, 1, "sq_a"); sq(68, 100, -100, 1, "sq_a");
    sq(61, 100, -100, 1, "sq_b");
    check("sq_avg64", 32'(period), 32'd64);
    sq(62, 100, -100, 1, "sq_b"); sq(62, 100, -100, 1, "sq_b"); sq(62, 100, -100, 1, "sq_b");
    tick(1'b1, 100, "sq_close");
    check("sq_trunc61", 32'(period), 32'd61);

    // loss of signal after lock
    apply_reset("rst_lost");
    for (int i = 0; i < 5; i++) sq(64, 100, -100, 1, "lost_lock");
    tick(1'b1, 100, "lost_close");
    check("lost_locked", 32'(locked), 32'd1);
    n_lost = 0;
    repeat (4200) tick(1'b1, 0, "lost_flat");
    check("lost_pulses", 32'(n_lost), 32'd1);
    check("lost_unlocked", 32'(locked), 32'd0);
    check("lost_stale", 32'(period), 32'd64);
    n_valid = 0;
    tick(1'b1, -100, "relock_dip");
    for (int i = 0; i < 4; i++) sq(64, 100, -100, 1, "relock");
    check("relock_none", 32'(n_valid), 32'd0);
    tick(1'b1, 100, "relock_close");
    check("relock_one", 32'(n_valid), 32'd1);

    // sub-hysteresis noise, then a glitch inside a period
    apply_reset("rst_noise");
    n_valid = 0;
    repeat (200) tick(1'b1, int'($urandom_range(0, 10)) - 5, "noise");
    check("noise_nvalid", 32'(n_valid), 32'd0);
    check("noise_locked", 32'(locked), 32'd0);
    tick(1'b1, -100, "spk_dip");
    for (int i = 0; i < 4; i++) sq(64, 100, -100, 1, "spk_lock");
    tick(1'b1, 100, "spk_x"); tick(1'b1, -100, "spk_dip2"); tick(1'b1, 100, "spike");
    repeat (61) tick(1'b1, -100, "spk_low");
    for (int i = 0; i < 3; i++) sq(64, 100, -100, 1, "spk_tail");
    tick(1'b1, 100, "spk_close");
    check("spike_period", 32'(period), 32'd64);
    check("spike_nvalid", 32'(n_valid), 32'd2);

    // randomized square waves with hysteresis-boundary noise
    for (int r = 0; r < 4; r++) begin
      int gap;
      apply_reset("rst_rand");
      gap = int'($urandom_range(1, 3));
      for (int i = 0; i < 14; i++)
        sq(int'($urandom_range(20, 120)), int'($urandom_range(8, 127)),
           -int'($urandom_range(8, 128)), gap, "rand_sq");
      repeat (60) tick(1'($urandom_range(0, 1)), int'($urandom_range(0, 40)) - 20, "rand_noise");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
